// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  localparam int BYTE_W      = 8;
  localparam int DEF_TIMEOUT = 255;

  // Counter width for a saturating count up to t; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART write-port bundle for the arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  import uart_arb_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_en;
  logic                    tx_full;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic                    timeout_pulse;

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_data, tx_en, grant, busy, timeout_pulse
  );

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_data, tx_en, grant, busy, timeout_pulse
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker starting after the last-served index
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic             o_found,
  output logic [IW-1:0]    o_idx
);

  logic [IW-1:0] w_j;

  // Walk the rotation from farthest to nearest so the nearest valid index is written last and wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_j = IW'((int'(i_last) + k) % N_REQ);
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin sharing of one UART transmit byte port
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               RSTn,
  uart_tx_arbiter_if.slave   bus
);

  localparam int            CW     = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  arb_state_t        r_state, w_state_nxt;
  logic [IW-1:0]     r_owner, w_owner_nxt;
  logic [IW-1:0]     r_last, w_last_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;

  logic              w_found;
  logic [IW-1:0]     w_pick;
  logic              w_own_valid;
  logic              w_own_last;
  logic [BYTE_W-1:0] w_own_data;
  logic              w_xfer;
  logic              w_timeout;

  logic [N_REQ-1:0]  w_req_ready;
  logic [N_REQ-1:0]  w_grant;
  logic [BYTE_W-1:0] w_tx_data;
  logic              w_tx_en;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (bus.req_valid),
    .i_last  (r_last),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_own_valid = bus.req_valid[r_owner];
  assign w_own_last  = bus.req_last[r_owner];
  assign w_own_data  = bus.req_data[BYTE_W*int'(r_owner) +: BYTE_W];
  assign w_xfer      = (r_state == ST_LOCK) && w_own_valid && !bus.tx_full;

  // Only an owner that has gone quiet can time out; a byte stalled by tx_full keeps the lock alive.
  assign w_timeout   = (TIMEOUT != 0) && (r_state == ST_LOCK) && !w_own_valid && (r_cnt == TO_MAX);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    w_req_ready = '0;
    w_grant     = '0;
    w_tx_data   = '0;
    w_tx_en     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_LOCK;
          w_owner_nxt = w_pick;
        end
      end
      ST_LOCK: begin
        w_grant[r_owner]     = 1'b1;
        w_req_ready[r_owner] = !bus.tx_full;
        if (w_xfer) begin
          w_tx_en   = 1'b1;
          w_tx_data = w_own_data;
          if (w_own_last) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_owner;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
        end else if (!w_own_valid) begin
          w_cnt_nxt = (r_cnt == TO_MAX) ? r_cnt : r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.grant         = w_grant;
  assign bus.tx_data       = w_tx_data;
  assign bus.tx_en         = w_tx_en;
  assign bus.busy          = (r_state == ST_LOCK);
  assign bus.timeout_pulse = w_timeout;

endmodule
